multicycle_addsub: RTL

MULTICYCLE_ADDSUB -- requirements
Module: multicycle_addsub

---
 rtl/multicycle_addsub.sv | 114 +++++++++++
 1 files changed

// File: rtl/multicycle_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK_WIDTH slice of the carry chain per clock,
// LSB chunk first. Flags and result update only once the last chunk is done.
module multicycle_addsub #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  overflow,
    output logic                  zero,
    output logic                  busy,
    output logic                  complete
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam int MSB = DATA_WIDTH - 1;

    if (DATA_WIDTH < 2 || CHUNK_WIDTH < 1 || (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : gen_bad_params
        $error("multicycle_addsub: DATA_WIDTH must be >= 2 and a multiple of CHUNK_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  mode_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  chain_q;
    // Partial result; kept separate so intermediate chunks never reach 'result'.
    logic [DATA_WIDTH-1:0] shadow_q;

    logic [DATA_WIDTH-1:0]  b_eff;
    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH:0]   chunk_sum;
    logic [DATA_WIDTH-1:0]  shadow_next;
    logic                   signed_ovf;
    int                     offset;

    // One chunk of the ripple chain; subtract uses ~b with the chain seeded to 1.
    always_comb begin
        b_eff       = mode_q ? ~b_q : b_q;
        offset      = int'(idx_q) * CHUNK_WIDTH;
        a_chunk     = a_q[offset +: CHUNK_WIDTH];
        b_chunk     = b_eff[offset +: CHUNK_WIDTH];
        chunk_sum   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, chain_q};
        shadow_next = shadow_q;
        shadow_next[offset +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
        signed_ovf  = (a_q[MSB] == b_eff[MSB]) && (shadow_next[MSB] != a_q[MSB]);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            chain_q  <= 1'b0;
            shadow_q <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            complete <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    complete <= 1'b0;
                    if (start) begin
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        mode_q  <= mode;
                        idx_q   <= '0;
                        chain_q <= mode;
                        busy    <= 1'b1;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    shadow_q <= shadow_next;
                    chain_q  <= chunk_sum[CHUNK_WIDTH];
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        result   <= shadow_next;
                        // Borrow is the inverse of the carry out of a + ~b + 1.
                        carry    <= mode_q ? ~chunk_sum[CHUNK_WIDTH] : chunk_sum[CHUNK_WIDTH];
                        overflow <= signed_ovf;
                        zero     <= (shadow_next == '0);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    complete <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
